// File: rtl/mm_timer_slave.sv
// mm_timer_slave: memory-mapped down-counting timer with prescaler,
// one-shot / auto-reload modes and a level interrupt.
module mm_timer_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int PRESCALE   = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  irq
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] PSC_MAX = 16'(PRESCALE - 1);

  state_t                state;
  logic                  auto_reload;
  logic                  irq_en;
  logic                  expired;
  logic [DATA_WIDTH-1:0] load;
  logic [DATA_WIDTH-1:0] count;
  logic [15:0]           psc;

  logic wr_ctrl, wr_load, wr_count, wr_stat;
  logic run, tick, zero, expire;
  logic run_nxt, start;
  logic unused_ok;

  assign unused_ok = ^{address[DATA_WIDTH-1:4], address[1:0]};

  assign wr_ctrl  = we && (address[3:2] == 2'd0);
  assign wr_load  = we && (address[3:2] == 2'd1);
  assign wr_count = we && (address[3:2] == 2'd2);
  assign wr_stat  = we && (address[3:2] == 2'd3);

  assign run    = (state == RUN);
  assign tick   = run && (psc == PSC_MAX);
  assign zero   = (count == '0);
  // A COUNT write on the same edge swallows the tick's expiry
  assign expire = tick && zero && !wr_count;

  always_comb begin
    run_nxt = run;
    if (wr_ctrl)
      run_nxt = wd[0];
    else if (expire && !auto_reload)
      run_nxt = 1'b0;
  end

  assign start = !run && run_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      expired     <= 1'b0;
      load        <= '0;
      count       <= '0;
      psc         <= '0;
    end else begin
      state <= run_nxt ? RUN : IDLE;
      if (wr_ctrl) begin
        auto_reload <= wd[1];
        irq_en      <= wd[2];
      end
      if (wr_load)
        load <= wd;
      if (wr_count)
        count <= wd;
      else if (tick) begin
        if (!zero)
          count <= count - DATA_WIDTH'(1);
        else if (auto_reload)
          count <= load;
      end
      // Set beats write-1-to-clear
      if (expire)
        expired <= 1'b1;
      else if (wr_stat && wd[0])
        expired <= 1'b0;
      if (!run_nxt || start || wr_count || tick)
        psc <= '0;
      else
        psc <= psc + 16'd1;
    end
  end

  always_comb begin
    rd = '0;
    if (re) begin
      unique case (address[3:2])
        2'd0:    rd = DATA_WIDTH'({irq_en, auto_reload, run});
        2'd1:    rd = load;
        2'd2:    rd = count;
        default: rd = DATA_WIDTH'(expired);
      endcase
    end
  end

  assign irq = expired && irq_en;

endmodule

// File: tb/tb_mm_timer_slave.sv
// tb_mm_timer_slave: directed table and sequence checks of the
// timer slave with PRESCALE=4.
module tb_mm_timer_slave;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_LOAD = 32'h4;
  localparam logic [31:0] A_CNT  = 32'h8;
  localparam logic [31:0] A_STAT = 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wd;
  logic [31:0] address;
  logic        we;
  logic        re;
  logic [31:0] rd;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        re;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  mm_timer_slave #(
    .DATA_WIDTH(32),
    .PRESCALE  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wd     (wd),
    .address(address),
    .we     (we),
    .re     (re),
    .rd     (rd),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic rchk(input string name, input logic [31:0] a,
                      input logic [31:0] exp);
    address = a;
    re = 1'b1;
    #1;
    chk(name, rd, exp);
    re = 1'b0;
    address = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    wd = d;
    we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    wd = '0;
    address = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0;
    re = 1'b0;
    wd = '0;
    address = '0;
    cyc(2);
    rchk("rst_ctrl", A_CTRL, 32'h0);
    rchk("rst_load", A_LOAD, 32'h0);
    rchk("rst_cnt", A_CNT, 32'h0);
    rchk("rst_stat", A_STAT, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    cyc(1);

    // read sweep with the counter stopped
    wr(A_LOAD, 32'hA5A5_0003);
    wr(A_CNT, 32'h7);
    wr(A_CTRL, 32'hFFFF_FFF6);
    vecs[0]  = '{1'b0, 32'h4, 32'h0};
    vecs[1]  = '{1'b0, 32'h8, 32'h0};
    vecs[2]  = '{1'b1, 32'h0, 32'h6};
    vecs[3]  = '{1'b1, 32'h4, 32'hA5A5_0003};
    vecs[4]  = '{1'b1, 32'h8, 32'h7};
    vecs[5]  = '{1'b1, 32'hC, 32'h0};
    vecs[6]  = '{1'b1, 32'h10, 32'h6};
    vecs[7]  = '{1'b1, 32'h14, 32'hA5A5_0003};
    vecs[8]  = '{1'b1, 32'h18, 32'h7};
    vecs[9]  = '{1'b1, 32'h1C, 32'h0};
    vecs[10] = '{1'b1, 32'hFFFF_FFF6, 32'hA5A5_0003};
    vecs[11] = '{1'b1, 32'h0000_0109, 32'h7};
    for (int i = 0; i < 12; i++) begin
      address = vecs[i].addr;
      re = vecs[i].re;
      #1;
      chk($sformatf("sweep%0d", i), rd, vecs[i].exp);
      re = 1'b0;
    end
    address = '0;

    // auto-reload period (LOAD+1)*PRESCALE
    wr(A_LOAD, 32'h3);
    wr(A_CNT, 32'h3);
    wr(A_CTRL, 32'h7);
    cyc(15);
    rchk("ar_pre", A_STAT, 32'h0);
    chk("ar_pre_irq", 32'(irq), 32'h0);
    cyc(1);
    rchk("ar_exp", A_STAT, 32'h1);
    chk("ar_irq", 32'(irq), 32'h1);
    rchk("ar_reload", A_CNT, 32'h3);
    wr(A_STAT, 32'h1);
    rchk("ar_clr", A_STAT, 32'h0);
    chk("ar_clr_irq", 32'(irq), 32'h0);
    cyc(14);
    rchk("ar_pre2", A_STAT, 32'h0);
    cyc(1);
    rchk("ar_exp2", A_STAT, 32'h1);

    // clear on the same edge as the next expiry
    cyc(15);
    wr(A_STAT, 32'h1);
    rchk("w1c_race", A_STAT, 32'h1);
    chk("w1c_race_irq", 32'(irq), 32'h1);
    wr(A_STAT, 32'h1);
    rchk("w1c_late", A_STAT, 32'h0);
    chk("w1c_late_irq", 32'(irq), 32'h0);

    // COUNT write on a tick edge
    wr(A_CNT, 32'h6);
    cyc(4);
    rchk("cw_5", A_CNT, 32'h5);
    cyc(3);
    wr(A_CNT, 32'h10);
    rchk("cw_win", A_CNT, 32'h10);
    cyc(3);
    rchk("cw_hold", A_CNT, 32'h10);
    cyc(1);
    rchk("cw_dec", A_CNT, 32'hF);

    // reset mid-count
    rst_n = 1'b0;
    #1;
    rchk("mr_ctrl", A_CTRL, 32'h0);
    rchk("mr_load", A_LOAD, 32'h0);
    rchk("mr_cnt", A_CNT, 32'h0);
    chk("mr_irq", 32'(irq), 32'h0);
    cyc(1);
    rst_n = 1'b1;
    wr(A_CNT, 32'h5);
    cyc(10);
    rchk("mr_frozen", A_CNT, 32'h5);
    rchk("mr_idle", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h1);
    cyc(4);
    rchk("mr_run", A_CNT, 32'h4);

    // one-shot expiry
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h1);
    wr(A_CNT, 32'h2);
    wr(A_CTRL, 32'h1);
    cyc(11);
    rchk("os_pre", A_STAT, 32'h0);
    cyc(1);
    rchk("os_exp", A_STAT, 32'h1);
    rchk("os_ctrl", A_CTRL, 32'h0);
    rchk("os_cnt", A_CNT, 32'h0);
    chk("os_irq", 32'(irq), 32'h0);
    cyc(8);
    rchk("os_hold", A_CNT, 32'h0);

    // CTRL en write beats one-shot auto-clear
    wr(A_STAT, 32'h1);
    wr(A_CTRL, 32'h1);
    cyc(3);
    wr(A_CTRL, 32'h1);
    rchk("cr_en", A_CTRL, 32'h1);
    rchk("cr_exp", A_STAT, 32'h1);
    cyc(3);
    rchk("cr_still", A_CTRL, 32'h1);
    cyc(1);
    rchk("cr_stop", A_CTRL, 32'h0);

    // LOAD=0 with auto-reload expires every tick
    wr(A_STAT, 32'h1);
    wr(A_LOAD, 32'h0);
    wr(A_CNT, 32'h0);
    wr(A_CTRL, 32'h3);
    cyc(3);
    rchk("l0_pre", A_STAT, 32'h0);
    cyc(1);
    rchk("l0_exp", A_STAT, 32'h1);
    rchk("l0_ctrl", A_CTRL, 32'h3);
    wr(A_STAT, 32'h1);
    rchk("l0_clr", A_STAT, 32'h0);
    cyc(2);
    rchk("l0_pre2", A_STAT, 32'h0);
    cyc(1);
    rchk("l0_exp2", A_STAT, 32'h1);

    // LOAD write during a reload uses the old LOAD
    wr(A_CTRL, 32'h0);
    wr(A_LOAD, 32'h5);
    wr(A_CNT, 32'h0);
    wr(A_CTRL, 32'h3);
    cyc(3);
    wr(A_LOAD, 32'h9);
    rchk("lr_old", A_CNT, 32'h5);
    rchk("lr_new", A_LOAD, 32'h9);
    cyc(24);
    rchk("lr_next", A_CNT, 32'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_timer_slave.md
MM_TIMER_SLAVE -- requirements
Module: mm_timer_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bus data width; only 32 is supported.
REQ-002 Parameter PRESCALE, default 50: clk cycles per timer tick (1 us at 50 MHz); legal range 1..65535.
REQ-003 Port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port wd  input  DATA_WIDTH  write data from the memory-map master.
REQ-006 Port address  input  DATA_WIDTH  byte address; only address[3:2] is decoded, all other bits are ignored.
REQ-007 Port we  input  1  write select, already decoded by the master for this slave.
REQ-008 Port re  input  1  read select, already decoded by the master for this slave.
REQ-009 Port rd  output  DATA_WIDTH  read data.
REQ-010 Port irq  output  1  high when STATUS.expired=1 and CTRL.irq_en=1.

Function
REQ-011 Register map, selected by address[3:2]:
- 0 = CTRL: bit0 en, bit1 auto_reload, bit2 irq_en; all other bits read 0.
- 1 = LOAD: 32-bit reload value.
- 2 = COUNT: 32-bit current count.
- 3 = STATUS: bit0 expired; write-1-to-clear.
REQ-012 rd SHALL be combinational: the selected register when re=1, otherwise 32'h0; a read SHALL have no side effects.
REQ-013 A write SHALL take effect on the clk edge where we=1; writes to STATUS with wd[0]=0 SHALL be ignored.
REQ-014 FSM states:
- IDLE: CTRL.en=0.
- RUN: CTRL.en=1.
- Transitions: IDLE->RUN on a CTRL write with wd[0]=1; RUN->IDLE on a CTRL write with wd[0]=0, or on a one-shot expiry.
REQ-015 Prescaler: an internal counter psc counts 0..PRESCALE-1 while in RUN; a tick SHALL be generated on the cycle psc==PRESCALE-1, and psc then wraps to 0.
REQ-016 psc SHALL be held at 0 in IDLE, and SHALL be cleared on the IDLE->RUN transition and on any COUNT write.
REQ-017 On a tick with COUNT!=0: COUNT SHALL decrement by 1.
REQ-018 On a tick with COUNT==0:
- expired SHALL be set.
- If auto_reload=1: COUNT<=LOAD and the FSM stays in RUN.
- Else: COUNT stays 0, CTRL.en is cleared, and the FSM goes to IDLE.
REQ-019 Expiry period: with auto_reload=1, successive expiries SHALL be (LOAD+1)*PRESCALE cycles apart.
REQ-020 A COUNT write coinciding with a tick: the written value SHALL win and that tick's decrement/expiry SHALL be discarded.
REQ-021 A CTRL write coinciding with a tick:
- The written CTRL value SHALL win.
- The tick's COUNT update and expiry SHALL still apply.
- If the tick is a one-shot expiry, the CTRL write of en SHALL win over the auto-clear of en.
REQ-022 A STATUS write-1-to-clear coinciding with a new expiry: set SHALL win, so expired remains 1.
REQ-023 A LOAD write coinciding with an auto-reload: COUNT SHALL take the old LOAD value; the new LOAD applies from the next reload.
REQ-024 LOAD=0 with auto_reload=1 SHALL expire on every tick.
REQ-025 irq SHALL be combinational from registered state, with no extra latency beyond the expired register.

Reset
REQ-026 While rst_n=0, asynchronously:
- CTRL=0, LOAD=0, COUNT=0, expired=0, psc=0, FSM=IDLE.
- irq=0; rd=0 unless re=1, in which case rd returns the reset register value (0).
REQ-027 Reset asserted mid-count SHALL abort the count immediately; after release the block SHALL stay in IDLE until CTRL is written.

Verification
REQ-028 PRESCALE=4; write LOAD=3, COUNT=3, CTRL=3'b111 -> expired and irq rise exactly 16 cycles after the CTRL write edge; COUNT reloads to 3; the next expiry occurs 16 cycles later.
REQ-029 One-shot: COUNT=2, CTRL=3'b001, PRESCALE=4 -> expired=1 at 12 cycles; CTRL reads 0; COUNT holds 0; irq stays 0 (irq_en=0).
REQ-030 Write STATUS=1 on the same edge as an expiry -> expired stays 1; a STATUS=1 write one cycle later clears it and irq drops.
REQ-031 Write COUNT=32'h10 on a tick edge while COUNT=5 -> COUNT reads 32'h10 the next cycle; no decrement is applied on that edge.
REQ-032 Read sweep with re=0 -> rd=0; re=1 at addresses 0x0/0x4/0x8/0xC (and aliases 0x10/0x14/0x18/0x1C) -> the expected register values.
REQ-033 Assert rst_n=0 for one cycle mid-count -> all registers read 0; the counter stays frozen until CTRL.en is written.
